// File: rtl/biss_pkg.sv
// Shared definitions for the BiSS-C read-path scheduler: state encoding,
// protocol field widths and default timing constants.
package biss_pkg;

    localparam int unsigned CRC_W           = 6;
    localparam int unsigned ERR_W           = 2;
    localparam int unsigned POLL_PERIOD_DEF = 20000;
    localparam int unsigned RECOVER_CYC_DEF = 4000;
    localparam int unsigned CNT_W           = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_FAIL  = 3'd4,
        ST_RECOV = 3'd5
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/biss_poll_timer.sv
// Periodic poll counter; tick is high for the single cycle in which the
// counter sits at POLL_PERIOD-1 while polling is enabled.
module biss_poll_timer
    import biss_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = POLL_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic poll_en,
    output logic tick
);

    logic [CNT_W-1:0] cnt_r;

    // Free-running counter, held at zero while polling is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!poll_en) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_W'(POLL_PERIOD - 1)) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign tick = poll_en & (cnt_r == CNT_W'(POLL_PERIOD - 1));

endmodule

// File: rtl/biss_poll_sched.sv
// BiSS-C transaction scheduler: merges poll/key requests, sequences the frame
// engine, validates CRC with retry. Optional stats: BISS_SCHED_STATS_EN.
module biss_poll_sched
    import biss_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = POLL_PERIOD_DEF,
    parameter int unsigned TIMEOUT_CYC = 4000,
    parameter int unsigned RECOVER_CYC = RECOVER_CYC_DEF,
    parameter int unsigned CRC_LAT     = 2,
    parameter int unsigned MAX_RETRY   = 2,
    parameter int unsigned DATA_W      = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              poll_en,
    input  logic              key_req,
    output logic              frame_start,
    input  logic              frame_busy,
    input  logic              frame_done,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ERR_W-1:0]  err_in,
    input  logic [CRC_W-1:0]  crc_rx,
    input  logic [CRC_W-1:0]  crc_calc,
    output logic              crc_en,
    output logic [DATA_W-1:0] pos_out,
    output logic              pos_valid,
    output logic [ERR_W-1:0]  status,
    output logic              fault
`ifdef BISS_SCHED_STATS_EN
    ,
    output logic [15:0]       crc_err_cnt,
    output logic [15:0]       timeout_cnt
`endif
);

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                pend_r;
    logic [7:0]          retry_r;
    logic                frame_start_r;
    logic                pos_valid_r;
    logic                fault_r;
    logic [DATA_W-1:0]   pos_out_r;
    logic [ERR_W-1:0]    status_r;
    logic                tick_s;
    logic                req_s;
    logic                cmp_s;
    logic                mismatch_s;
    logic                timeout_s;

    biss_poll_timer #(
        .POLL_PERIOD (POLL_PERIOD)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .poll_en (poll_en),
        .tick    (tick_s)
    );

    assign req_s      = tick_s | key_req;
    assign cmp_s      = (state_r == ST_CHECK) && (cnt_r == CNT_W'(CRC_LAT));
    assign mismatch_s = cmp_s && (crc_calc != crc_rx);
    assign timeout_s  = (state_r == ST_WAIT) && !frame_done && (cnt_r == {CNT_W{1'b0}});

    // crc_en must coincide with frame_done, so it cannot be registered
    assign crc_en      = (state_r == ST_WAIT) & frame_done;
    assign frame_start = frame_start_r;
    assign pos_valid   = pos_valid_r;
    assign pos_out     = pos_out_r;
    assign status      = status_r;
    assign fault       = fault_r;

    // Scheduler FSM; cnt_r is shared as timeout, CRC-latency and recovery counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            pend_r        <= 1'b0;
            retry_r       <= 8'd0;
            frame_start_r <= 1'b0;
            pos_valid_r   <= 1'b0;
            fault_r       <= 1'b0;
            pos_out_r     <= {DATA_W{1'b0}};
            status_r      <= {ERR_W{1'b0}};
        end else begin
            frame_start_r <= 1'b0;
            pos_valid_r   <= 1'b0;
            if (req_s) begin
                pend_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pend_r || req_s) begin
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    frame_start_r <= 1'b1;
                    cnt_r         <= CNT_W'(TIMEOUT_CYC);
                    pend_r        <= req_s;
                    state_r       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (frame_done) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_CHECK;
                    end else if (timeout_s) begin
                        state_r <= ST_FAIL;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_CHECK: begin
                    if (!cmp_s) begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (!mismatch_s) begin
                        pos_out_r   <= data_in;
                        status_r    <= err_in;
                        pos_valid_r <= 1'b1;
                        retry_r     <= 8'd0;
                        fault_r     <= 1'b0;
                        cnt_r       <= CNT_W'(RECOVER_CYC - 1);
                        state_r     <= ST_RECOV;
                    end else begin
                        state_r <= ST_FAIL;
                    end
                end
                ST_FAIL: begin
                    if (retry_r < 8'(MAX_RETRY)) begin
                        retry_r <= retry_r + 8'd1;
                        pend_r  <= 1'b1;
                    end else begin
                        fault_r <= 1'b1;
                        retry_r <= 8'd0;
                    end
                    cnt_r   <= CNT_W'(RECOVER_CYC - 1);
                    state_r <= ST_RECOV;
                end
                ST_RECOV: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (!frame_busy) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BISS_SCHED_STATS_EN
    logic [15:0] crc_err_cnt_r;
    logic [15:0] timeout_cnt_r;

    // Saturating error statistics, cleared only by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_err_cnt_r <= 16'd0;
            timeout_cnt_r <= 16'd0;
        end else begin
            if (mismatch_s) begin
                crc_err_cnt_r <= sat_inc16(crc_err_cnt_r);
            end
            if (timeout_s) begin
                timeout_cnt_r <= sat_inc16(timeout_cnt_r);
            end
        end
    end

    assign crc_err_cnt = crc_err_cnt_r;
    assign timeout_cnt = timeout_cnt_r;
`endif

endmodule
